fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register and variable-latency imem handshake.
// Latency: zero-wait memory word requested in cycle t is on instrD in cycle t+1; 1 instr/cycle.
// Backpressure: stallD parks an acked word in a hold buffer; an unacked fetch raises fetch_stall.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0000,
    parameter logic [31:0] STALL_CNT_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        stallD,
    input  logic        flushD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pcF,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic        validD,
    output logic        fetch_stall,
    output logic [31:0] stall_cnt
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    state_t      state;
    logic [31:0] pcReg;
    logic [31:0] holdBuf;
    logic [31:0] stallCnt;
    ifid_t       ifid;

    logic        inFetch;
    logic        ackSeen;
    logic        advance;
    logic [31:0] word;

    // A request is outstanding only in FETCH and never while reset is applied;
    // an ack seen during reset belongs to a discarded request.
    assign inFetch  = (state == FETCH);
    assign ackSeen  = inFetch & imem_ack & ~rst;

    // The pipeline moves when a word is available (fresh ack or held) and decode is free.
    assign advance  = ~rst & ~stallD & (ackSeen | (state == HOLD));
    assign word     = (state == HOLD) ? holdBuf : imem_rdata;

    assign imem_req    = inFetch & ~rst;
    assign imem_addr   = pcReg;
    assign pcF         = pcReg;
    assign fetch_stall = inFetch & ~imem_ack & ~rst;

    assign instrD = ifid.instr;
    assign pcD    = ifid.pc;
    assign validD = ifid.valid;

    // Fetch FSM, PC, hold buffer and IF/ID register; npc is only sampled on an advance
    // so a branch resolved under stallD redirects exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pcReg      <= RESET_PC;
            holdBuf    <= NOP_INSTR;
            ifid.pc    <= 32'h0;
            ifid.instr <= NOP_INSTR;
            ifid.valid <= 1'b0;
        end else begin
            if (advance) begin
                ifid.pc    <= pcReg;
                ifid.instr <= flushD ? NOP_INSTR : word;
                ifid.valid <= ~flushD;
                pcReg      <= npc;
                state      <= FETCH;
            end else if (ackSeen && stallD) begin
                // Decode cannot take the word yet: park it instead of re-fetching.
                holdBuf <= imem_rdata;
                state   <= HOLD;
            end
        end
    end

    // Saturating count of cycles spent waiting on instruction memory
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= STALL_CNT_INIT;
        end else if (fetch_stall && (stallCnt != CNT_MAX)) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

    assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, zero-wait, wait states, hold, flush, mid-fetch reset, saturation.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
// A second instance with a preloaded counter never sees an ack and exercises saturation.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] npc;
    logic        stallD;
    logic        flushD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pcF;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic        validD;
    logic        fetch_stall;
    logic [31:0] stall_cnt;

    logic        satReq;
    logic [31:0] satAddr;
    logic        satAck;
    logic [31:0] satRdata;
    logic [31:0] satPcF;
    logic [31:0] satInstrD;
    logic [31:0] satPcD;
    logic        satValidD;
    logic        satFetchStall;
    logic [31:0] satStallCnt;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .npc        (npc),
        .stallD     (stallD),
        .flushD     (flushD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pcF        (pcF),
        .instrD     (instrD),
        .pcD        (pcD),
        .validD     (validD),
        .fetch_stall(fetch_stall),
        .stall_cnt  (stall_cnt)
    );

    fetch_unit #(.STALL_CNT_INIT(32'hFFFF_FFFD)) dutSat (
        .clk        (clk),
        .rst        (rst),
        .npc        (npc),
        .stallD     (stallD),
        .flushD     (flushD),
        .imem_req   (satReq),
        .imem_addr  (satAddr),
        .imem_ack   (satAck),
        .imem_rdata (satRdata),
        .pcF        (satPcF),
        .instrD     (satInstrD),
        .pcD        (satPcD),
        .validD     (satValidD),
        .fetch_stall(satFetchStall),
        .stall_cnt  (satStallCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, still well before the next rising edge
    task automatic settle();
        #3;
    endtask

    initial begin
        rst        = 1'b1;
        npc        = 32'h0;
        stallD     = 1'b0;
        flushD     = 1'b0;
        imem_ack   = 1'b1;          // stale ack during reset
        imem_rdata = 32'hDEAD_BEEF;
        satAck     = 1'b0;
        satRdata   = 32'h0;

        // ---------------- reset ----------------
        tick();
        check("rst_req",    {31'b0, imem_req}, 32'h0);
        check("rst_pcF",    pcF,               32'h0000_3000);
        check("rst_instrD", instrD,            32'h0000_0000);
        check("rst_pcD",    pcD,               32'h0000_0000);
        check("rst_validD", {31'b0, validD},   32'h0);
        check("rst_cnt",    stall_cnt,         32'h0);
        tick();
        check("rst_stale_valid", {31'b0, validD}, 32'h0);
        check("sat_init",        satStallCnt,     32'hFFFF_FFFD);

        // ---------------- zero-wait fetch of 0x3000 ----------------
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hC0DE_3000; npc = 32'h0000_3004;
        settle();
        check("s1_req",   {31'b0, imem_req},    32'h1);
        check("s1_addr",  imem_addr,            32'h0000_3000);
        check("s1_fstl",  {31'b0, fetch_stall}, 32'h0);
        tick();
        check("s1_instrD", instrD,          32'hC0DE_3000);
        check("s1_validD", {31'b0, validD}, 32'h1);
        check("s1_pcD",    pcD,             32'h0000_3000);
        check("s1_pcF",    pcF,             32'h0000_3004);

        // ---------------- 3 wait cycles at 0x3004 ----------------
        imem_ack = 1'b0; imem_rdata = 32'hBAAD_F00D; npc = 32'h0000_BAD0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("w_fstl", {31'b0, fetch_stall}, 32'h1);
            check("w_addr", imem_addr,            32'h0000_3004);
            tick();
            check("w_instrD", instrD, 32'hC0DE_3000);
        end
        imem_ack = 1'b1; imem_rdata = 32'hC0DE_3004; npc = 32'h0000_3008;
        settle();
        check("w_ack_fstl", {31'b0, fetch_stall}, 32'h0);
        tick();
        check("w_instrD_new", instrD,    32'hC0DE_3004);
        check("w_pcD",        pcD,       32'h0000_3004);
        check("w_pcF",        pcF,       32'h0000_3008);
        check("w_cnt",        stall_cnt, 32'd3);
        check("sat_hold",     satStallCnt, 32'hFFFF_FFFF);
        check("sat_fstl",     {31'b0, satFetchStall}, 32'h1);

        // ---------------- ack at 0x3008 while stallD for 2 cycles ----------------
        stallD = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hC0DE_3008; npc = 32'h0000_300C;
        settle();
        check("h_req0", {31'b0, imem_req}, 32'h1);
        check("h_addr", imem_addr,         32'h0000_3008);
        tick();
        check("h_instrD0", instrD, 32'hC0DE_3004);
        check("h_pcF0",    pcF,    32'h0000_3008);
        imem_ack = 1'b0; imem_rdata = 32'h1111_1111; npc = 32'h0000_BAD4;
        settle();
        check("h_req1",  {31'b0, imem_req},    32'h0);
        check("h_fstl1", {31'b0, fetch_stall}, 32'h0);
        tick();
        check("h_instrD1", instrD, 32'hC0DE_3004);
        stallD = 1'b0; npc = 32'h0000_300C; imem_rdata = 32'h2222_2222;
        settle();
        check("h_req2", {31'b0, imem_req}, 32'h0);
        tick();
        check("h_instrD2", instrD,          32'hC0DE_3008);
        check("h_pcD2",    pcD,             32'h0000_3008);
        check("h_pcF2",    pcF,             32'h0000_300C);
        check("h_validD2", {31'b0, validD}, 32'h1);
        check("h_cnt",     stall_cnt,       32'd3);

        // ---------------- flush on advance, redirect to 0x3100 ----------------
        flushD = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hC0DE_300C; npc = 32'h0000_3100;
        settle();
        check("f_addr", imem_addr, 32'h0000_300C);
        tick();
        check("f_instrD", instrD,          32'h0000_0000);
        check("f_validD", {31'b0, validD}, 32'h0);
        check("f_pcF",    pcF,             32'h0000_3100);
        check("f_pcD",    pcD,             32'h0000_300C);
        flushD = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hC0DE_3100; npc = 32'h0000_3104;
        settle();
        check("f_next_addr", imem_addr, 32'h0000_3100);
        tick();
        check("f_next_instrD", instrD,          32'hC0DE_3100);
        check("f_next_validD", {31'b0, validD}, 32'h1);

        // ---------------- flush with no advance is ignored ----------------
        flushD = 1'b1; imem_ack = 1'b0; npc = 32'h0000_BAD8;
        tick();
        check("fn_instrD", instrD,          32'hC0DE_3100);
        check("fn_validD", {31'b0, validD}, 32'h1);
        check("fn_pcF",    pcF,             32'h0000_3104);
        check("fn_cnt",    stall_cnt,       32'd4);

        // ---------------- reset in the middle of a slow fetch ----------------
        flushD = 1'b0;
        tick();
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        settle();
        check("mr_req", {31'b0, imem_req}, 32'h0);
        tick();
        check("mr_pcF",    pcF,             32'h0000_3000);
        check("mr_instrD", instrD,          32'h0000_0000);
        check("mr_pcD",    pcD,             32'h0000_0000);
        check("mr_validD", {31'b0, validD}, 32'h0);
        check("mr_cnt",    stall_cnt,       32'h0);
        check("mr_req2",   {31'b0, imem_req}, 32'h0);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hC0DE_3000; npc = 32'h0000_3004;
        settle();
        check("mr_first_req",  {31'b0, imem_req}, 32'h1);
        check("mr_first_addr", imem_addr,         32'h0000_3000);
        tick();
        check("mr_first_instrD", instrD,          32'hC0DE_3000);
        check("mr_first_validD", {31'b0, validD}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
